// File: rtl/iiitb_lifo_param.sv
// Parametrised LIFO stack with push/pop strobes, top replace, occupancy flags
// and sticky overflow/underflow error reporting.
module iiitb_lifo_param #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AF_TH  = 6,
    parameter int AE_TH  = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EN,
    input  logic              CLR,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic [DATA_W-1:0] TOP,
    output logic [CW-1:0]     COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_EMPTY,
    output logic              ALMOST_FULL,
    output logic              OVF,
    output logic              UNF,
    output logic              ERR
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     push_idx;
    logic [AW-1:0]     top_idx;
    logic [DATA_W-1:0] top_data;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic          cnt_inc;
    logic          cnt_dec;
    logic          pop_take;
    logic          bypass;
    logic          ovf_n;
    logic          unf_n;

    assign push_idx = AW'(COUNT);
    assign top_idx  = AW'(COUNT - CW'(1));
    assign top_data = mem[top_idx];

    // Every flag is a pure function of the COUNT register
    assign EMPTY        = (COUNT == '0);
    assign FULL         = (COUNT == CW'(DEPTH));
    assign ALMOST_EMPTY = (COUNT <= CW'(AE_TH));
    assign ALMOST_FULL  = (COUNT >= CW'(AF_TH));
    assign TOP          = EMPTY ? '0 : top_data;

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = push_idx;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        pop_take = 1'b0;
        bypass   = 1'b0;
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        if (EN && !CLR) begin
            unique case ({PUSH, POP})
                2'b10: begin
                    if (FULL) begin
                        ovf_n = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
                2'b01: begin
                    if (EMPTY) begin
                        unf_n = 1'b1;
                    end else begin
                        pop_take = 1'b1;
                        cnt_dec  = 1'b1;
                    end
                end
                2'b11: begin
                    // Top replace; on an empty stack the word passes straight through
                    if (EMPTY) begin
                        bypass = 1'b1;
                    end else begin
                        pop_take = 1'b1;
                        wr_en    = 1'b1;
                        wr_idx   = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_idx] <= dataIn;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            COUNT     <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            dataValid <= pop_take | bypass;
            OVF       <= ovf_n;
            UNF       <= unf_n;
            if (pop_take) begin
                dataOut <= top_data;
            end else if (bypass) begin
                dataOut <= dataIn;
            end
            if (CLR) begin
                COUNT <= '0;
                ERR   <= 1'b0;
            end else begin
                ERR <= ERR | ovf_n | unf_n;
                if (cnt_inc) begin
                    COUNT <= COUNT + CW'(1);
                end else if (cnt_dec) begin
                    COUNT <= COUNT - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_iiitb_lifo_param.sv
// Directed self-checking bench for iiitb_lifo_param (DATA_W=4, DEPTH=8,
// AF_TH=6, AE_TH=2).
module tb_iiitb_lifo_param;

    logic       Clk;
    logic       Rst;
    logic       EN;
    logic       CLR;
    logic       PUSH;
    logic       POP;
    logic [3:0] dataIn;
    logic [3:0] dataOut;
    logic       dataValid;
    logic [3:0] TOP;
    logic [3:0] COUNT;
    logic       EMPTY;
    logic       FULL;
    logic       ALMOST_EMPTY;
    logic       ALMOST_FULL;
    logic       OVF;
    logic       UNF;
    logic       ERR;

    int checks;
    int errors;

    iiitb_lifo_param #(
        .DATA_W(4),
        .DEPTH (8),
        .AF_TH (6),
        .AE_TH (2)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .EN          (EN),
        .CLR         (CLR),
        .PUSH        (PUSH),
        .POP         (POP),
        .dataIn      (dataIn),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .TOP         (TOP),
        .COUNT       (COUNT),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY),
        .ALMOST_FULL (ALMOST_FULL),
        .OVF         (OVF),
        .UNF         (UNF),
        .ERR         (ERR)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Apply one operation across a rising edge; outputs are checked 1ns after it
    task automatic step(input logic push, input logic pop, input logic [3:0] din);
        PUSH   = push;
        POP    = pop;
        dataIn = din;
        @(posedge Clk);
        #1;
        PUSH = 1'b0;
        POP  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst    = 1'b1;
        EN     = 1'b0;
        CLR    = 1'b0;
        PUSH   = 1'b0;
        POP    = 1'b0;
        dataIn = 4'h0;
        #1;
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_dout", dataOut, 0);
        chk("rst_dvalid", dataValid, 0);
        chk("rst_err", ERR, 0);
        chk("rst_ae", ALMOST_EMPTY, 1);
        chk("rst_top", TOP, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        EN  = 1'b1;

        // Basic push/pop ordering
        for (int i = 0; i < 4; i++) step(1, 0, 4'(2 * i));
        chk("t1_count", COUNT, 4);
        chk("t1_top", TOP, 6);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 4'h0);
            chk("t1_pop_dout", dataOut, 6 - 2 * i);
            chk("t1_pop_dv", dataValid, 1);
        end
        chk("t1_empty", EMPTY, 1);
        step(0, 0, 4'h0);
        chk("t1_idle_dv", dataValid, 0);
        chk("t1_idle_dout", dataOut, 0);

        // Fill with 1..8, watching thresholds
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 4'(i));
            chk("t2_fill_count", COUNT, i);
            chk("t2_fill_af", ALMOST_FULL, (i >= 6) ? 1 : 0);
            chk("t2_fill_ae", ALMOST_EMPTY, (i <= 2) ? 1 : 0);
        end
        chk("t2_full", FULL, 1);
        step(1, 0, 4'hF);
        chk("t2_ovf", OVF, 1);
        chk("t2_ovf_err", ERR, 1);
        chk("t2_ovf_count", COUNT, 8);
        chk("t2_ovf_top", TOP, 8);
        step(0, 0, 4'h0);
        chk("t2_ovf_pulse", OVF, 0);
        chk("t2_err_sticky", ERR, 1);

        // Top replace while full
        step(1, 1, 4'hA);
        chk("t4_dout", dataOut, 8);
        chk("t4_dv", dataValid, 1);
        chk("t4_top", TOP, 4'hA);
        chk("t4_count", COUNT, 8);
        chk("t4_ovf", OVF, 0);

        // Disabled operations are ignored
        EN = 1'b0;
        step(1, 0, 4'h3);
        chk("t5_en0_push_count", COUNT, 8);
        chk("t5_en0_push_top", TOP, 4'hA);
        step(0, 1, 4'h0);
        chk("t5_en0_pop_count", COUNT, 8);
        chk("t5_en0_pop_dv", dataValid, 0);
        chk("t5_en0_pop_dout", dataOut, 8);
        EN = 1'b1;

        // Drain: A then 7..1
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 4'h0);
            chk("t5_drain_dout", dataOut, (k == 0) ? 10 : 8 - k);
            chk("t5_drain_count", COUNT, 7 - k);
            chk("t5_drain_ae", ALMOST_EMPTY, (7 - k <= 2) ? 1 : 0);
            chk("t5_drain_af", ALMOST_FULL, (7 - k >= 6) ? 1 : 0);
        end

        // CLR beats a concurrent push
        for (int i = 0; i < 3; i++) step(1, 0, 4'(i + 4));
        chk("t2_pre_clr_count", COUNT, 3);
        CLR = 1'b1;
        step(1, 0, 4'hC);
        CLR = 1'b0;
        chk("t2_clr_count", COUNT, 0);
        chk("t2_clr_err", ERR, 0);
        chk("t2_clr_dv", dataValid, 0);
        chk("t2_clr_dout", dataOut, 1);

        // Underflow and empty bypass
        step(0, 1, 4'h0);
        chk("t3_unf", UNF, 1);
        chk("t3_unf_dv", dataValid, 0);
        chk("t3_unf_dout", dataOut, 1);
        chk("t3_unf_err", ERR, 1);
        step(1, 1, 4'h9);
        chk("t3_byp_dout", dataOut, 9);
        chk("t3_byp_dv", dataValid, 1);
        chk("t3_byp_count", COUNT, 0);
        chk("t3_byp_unf", UNF, 0);

        // CLR acts with EN low
        EN  = 1'b0;
        CLR = 1'b1;
        step(0, 0, 4'h0);
        CLR = 1'b0;
        EN  = 1'b1;
        chk("t3_clr_en0_err", ERR, 0);
        chk("t3_clr_en0_dout", dataOut, 9);

        // Asynchronous reset between edges
        step(1, 0, 4'h5);
        step(1, 0, 4'h6);
        chk("t6_pre_count", COUNT, 2);
        PUSH   = 1'b1;
        dataIn = 4'h7;
        #2;
        Rst = 1'b1;
        #1;
        chk("t6_async_count", COUNT, 0);
        chk("t6_async_empty", EMPTY, 1);
        chk("t6_async_dout", dataOut, 0);
        chk("t6_async_top", TOP, 0);
        PUSH = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
